// File: rtl/divider_rate_sequencer.sv
// Rate-select sequencer for the programmable clock divider: sweeps the select
// between two endpoints, dwelling a programmed number of divider edges per step.
module divider_rate_sequencer #(
    parameter int SEL_W          = 5,
    parameter int DWELL_W        = 8,
    parameter bit RESYNC_ON_STEP = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [1:0]         mode_i,
    input  logic [SEL_W-1:0]   start_sel_i,
    input  logic [SEL_W-1:0]   end_sel_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               div_clk_i,
    output logic [SEL_W-1:0]   sel_o,
    output logic               div_rst_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   start_l_q, start_l_d;
    logic [SEL_W-1:0]   end_l_q, end_l_d;
    logic [SEL_W-1:0]   target_q, target_d;
    logic [DWELL_W-1:0] dwell_l_q, dwell_l_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic               dir_q, dir_d;
    logic               done_q, done_d;
    logic               resync_q, resync_d;
    logic               div_clk_q;
    logic               div_edge;

    assign div_edge = div_clk_i & ~div_clk_q;

    function automatic logic [SEL_W-1:0] step(input logic [SEL_W-1:0] s, input logic up);
        return up ? s + SEL_W'(1) : s - SEL_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            start_l_q   <= '0;
            end_l_q     <= '0;
            target_q    <= '0;
            dwell_l_q   <= '0;
            dwell_cnt_q <= '0;
            mode_q      <= '0;
            dir_q       <= 1'b0;
            done_q      <= 1'b0;
            resync_q    <= 1'b0;
            div_clk_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            start_l_q   <= start_l_d;
            end_l_q     <= end_l_d;
            target_q    <= target_d;
            dwell_l_q   <= dwell_l_d;
            dwell_cnt_q <= dwell_cnt_d;
            mode_q      <= mode_d;
            dir_q       <= dir_d;
            done_q      <= done_d;
            resync_q    <= resync_d;
            div_clk_q   <= div_clk_i;
        end
    end

    // Only the dwell-completing edge in RUN moves the select; the sweep never
    // steps past its target, so sel stays inside the programmed range.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        start_l_d   = start_l_q;
        end_l_d     = end_l_q;
        target_d    = target_q;
        dwell_l_d   = dwell_l_q;
        dwell_cnt_d = dwell_cnt_q;
        mode_d      = mode_q;
        dir_d       = dir_q;
        done_d      = 1'b0;
        resync_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    mode_d      = mode_i;
                    start_l_d   = start_sel_i;
                    end_l_d     = end_sel_i;
                    target_d    = end_sel_i;
                    dwell_l_d   = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
                    dir_d       = (end_sel_i >= start_sel_i);
                    sel_d       = start_sel_i;
                    dwell_cnt_d = '0;
                    state_d     = LOAD;
                end
            end
            LOAD: state_d = abort_i ? IDLE : RUN;
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (div_edge) begin
                    if (dwell_cnt_q + DWELL_W'(1) == dwell_l_q) begin
                        dwell_cnt_d = '0;
                        if (mode_q == 2'd2) begin
                            sel_d = sel_q;
                        end else if (sel_q != target_q) begin
                            sel_d    = step(sel_q, dir_q);
                            resync_d = RESYNC_ON_STEP;
                        end else if (mode_q == 2'd1) begin
                            if (start_l_q != end_l_q) begin
                                target_d = (target_q == end_l_q) ? start_l_q : end_l_q;
                                dir_d    = ~dir_q;
                                sel_d    = step(sel_q, ~dir_q);
                                resync_d = RESYNC_ON_STEP;
                            end
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_o     = sel_q;
        busy_o    = (state_q != IDLE);
        div_rst_o = (state_q != RUN) | resync_q;
        done_o    = done_q;
    end

endmodule

// File: tb/tb_divider_rate_sequencer.sv
// Directed bench for divider_rate_sequencer: sweeps, bounce, collisions and
// step resync, with one instance per RESYNC_ON_STEP setting on shared stimulus.
module tb_divider_rate_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [4:0] start_sel = 5'd0;
    logic [4:0] end_sel = 5'd0;
    logic [7:0] dwell = 8'd0;
    logic       div_clk = 1'b0;

    logic [4:0] sel0, sel1;
    logic       divrst0, divrst1, busy0, busy1, done0, done1;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    divider_rate_sequencer #(.SEL_W(5), .DWELL_W(8), .RESYNC_ON_STEP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .mode_i(mode),
        .start_sel_i(start_sel), .end_sel_i(end_sel), .dwell_i(dwell), .div_clk_i(div_clk),
        .sel_o(sel0), .div_rst_o(divrst0), .busy_o(busy0), .done_o(done0)
    );

    divider_rate_sequencer #(.SEL_W(5), .DWELL_W(8), .RESYNC_ON_STEP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .mode_i(mode),
        .start_sel_i(start_sel), .end_sel_i(end_sel), .dwell_i(dwell), .div_clk_i(div_clk),
        .sel_o(sel1), .div_rst_o(divrst1), .busy_o(busy1), .done_o(done1)
    );

    task automatic expect_state(input string name, input logic [4:0] s, input logic b,
                                input logic d, input logic r);
        checks++;
        if (sel0 !== s || busy0 !== b || done0 !== d || divrst0 !== r) begin
            $display("FAIL %s: got sel=%0d busy=%0b done=%0b div_rst=%0b, want sel=%0d busy=%0b done=%0b div_rst=%0b",
                     name, sel0, busy0, done0, divrst0, s, b, d, r);
        end else begin
            passed++;
        end
    endtask

    // One divider rising edge; returns at the negedge after it was counted.
    task automatic give_edge();
        @(negedge clk) div_clk = 1'b1;
        @(negedge clk) div_clk = 1'b0;
    endtask

    task automatic start_seq(input logic [1:0] m, input logic [4:0] s, input logic [4:0] e,
                             input logic [7:0] d);
        @(negedge clk);
        mode = m; start_sel = s; end_sel = e; dwell = d; start = 1'b1;
        @(negedge clk) start = 1'b0;
        expect_state("load", s, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        expect_state("run_entry", s, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        expect_state("reset_hold", 5'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        expect_state("reset_release", 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_up_sweep();
        start_seq(2'd0, 5'd24, 5'd26, 8'd2);
        give_edge(); expect_state("up_e1", 5'd24, 1'b1, 1'b0, 1'b0);
        give_edge(); expect_state("up_e2", 5'd25, 1'b1, 1'b0, 1'b0);
        give_edge(); expect_state("up_e3", 5'd25, 1'b1, 1'b0, 1'b0);
        give_edge(); expect_state("up_e4", 5'd26, 1'b1, 1'b0, 1'b0);
        give_edge(); expect_state("up_e5", 5'd26, 1'b1, 1'b0, 1'b0);
        give_edge(); expect_state("up_done", 5'd26, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        expect_state("up_done_clear", 5'd26, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_down_sweep();
        start_seq(2'd3, 5'd10, 5'd8, 8'd0);
        give_edge(); expect_state("down_e1", 5'd9, 1'b1, 1'b0, 1'b0);
        give_edge(); expect_state("down_e2", 5'd8, 1'b1, 1'b0, 1'b0);
        give_edge(); expect_state("down_done", 5'd8, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        expect_state("down_done_clear", 5'd8, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_bounce();
        logic [4:0] want [5];
        want = '{5'd26, 5'd25, 5'd26, 5'd25, 5'd26};
        start_seq(2'd1, 5'd25, 5'd26, 8'd1);
        for (int i = 0; i < 5; i++) begin
            give_edge();
            expect_state($sformatf("bounce_e%0d", i), want[i], 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        expect_state("bounce_abort", 5'd26, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        expect_state("bounce_abort_idle", 5'd26, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_collisions();
        @(negedge clk);
        mode = 2'd0; start_sel = 5'd5; end_sel = 5'd7; dwell = 8'd1;
        start = 1'b1; abort = 1'b1;
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        expect_state("start_abort_idle", 5'd26, 1'b0, 1'b0, 1'b1);
        start_seq(2'd0, 5'd20, 5'd20, 8'd2);
        @(negedge clk);
        mode = 2'd1; start_sel = 5'd0; end_sel = 5'd31; dwell = 8'd1; start = 1'b1;
        @(negedge clk) start = 1'b0;
        expect_state("start_in_run", 5'd20, 1'b1, 1'b0, 1'b0);
        give_edge(); expect_state("same_e1", 5'd20, 1'b1, 1'b0, 1'b0);
        give_edge(); expect_state("same_done", 5'd20, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_resync();
        start_seq(2'd0, 5'd3, 5'd5, 8'd1);
        give_edge();
        checks++;
        if (sel1 !== 5'd4 || divrst1 !== 1'b1 || divrst0 !== 1'b0)
            $display("FAIL resync_pulse1: got sel=%0d rst1=%0b rst0=%0b, want 4 1 0", sel1, divrst1, divrst0);
        else passed++;
        @(negedge clk);
        checks++;
        if (divrst1 !== 1'b0 || busy1 !== 1'b1)
            $display("FAIL resync_clear1: got rst1=%0b busy1=%0b, want 0 1", divrst1, busy1);
        else passed++;
        give_edge();
        checks++;
        if (sel1 !== 5'd5 || divrst1 !== 1'b1)
            $display("FAIL resync_pulse2: got sel=%0d rst1=%0b, want 5 1", sel1, divrst1);
        else passed++;
        @(negedge clk) rst = 1'b1;
        #1;
        checks++;
        if (sel1 !== 5'd0 || busy1 !== 1'b0 || divrst1 !== 1'b1 || done1 !== 1'b0)
            $display("FAIL midrun_rst: got sel=%0d busy=%0b div_rst=%0b done=%0b, want 0 0 1 0",
                     sel1, busy1, divrst1, done1);
        else passed++;
        expect_state("midrun_rst_dut0", 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_sweep();
        test_down_sweep();
        test_bounce();
        test_collisions();
        test_resync();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
